// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between the IFU (read-only)
// and the LSU (read/write with byte mask). One transaction in flight at a
// time; LSU has priority, but after MAX_LSU_STREAK consecutive LSU grants
// while the IFU waits, the IFU is forced through.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ifu_req_*/ifu_addr         IFU valid/ready read request
//   ifu_resp_valid/ifu_rdata   IFU one-cycle response pulse + held data
//   lsu_req_*/lsu_addr/wen/wdata/wmask  LSU valid/ready request
//   lsu_resp_valid/lsu_rdata   LSU one-cycle response pulse + held data
//   mem_req_*/mem_addr/wen/wdata/wmask  latched request towards memory
//   mem_resp_valid/mem_rdata   memory response
//   resp_err                   error flag alongside either resp_valid
//   busy                       FSM not in IDLE
//
// Optional: define MEM_ARB_TIMEOUT_EN to return an error response after
// TIMEOUT cycles in WAIT with no memory response.
module mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_LSU_STREAK = 4,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_err,
  output logic                busy
);
  localparam int unsigned MASK_W = DATA_W/8;
  localparam int unsigned STK_W  = $clog2(MAX_LSU_STREAK+1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mreq_t;

  state_t           state, state_nxt;
  logic [STK_W-1:0] streak;
  logic             owner_lsu;
  mreq_t            req_q;
  logic             ifu_win, lsu_win, grant, done, tmo;

  // Arbitration: LSU first unless the IFU has been starved for a full streak.
  always_comb begin
    ifu_win = ifu_req_valid && (!lsu_req_valid || streak == STK_W'(MAX_LSU_STREAK));
    lsu_win = lsu_req_valid && !ifu_win;
    grant   = ifu_win || lsu_win;
  end

  assign done = (state == S_WAIT) && (mem_resp_valid || tmo);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant)         state_nxt = S_ISSUE;
      S_ISSUE: if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (done)          state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Output logic. Readies are qualified with rst_n so every output reads 0
  // while reset is held, even if requesters keep their valids up.
  always_comb begin
    ifu_req_ready = rst_n && (state == S_IDLE) && ifu_win;
    lsu_req_ready = rst_n && (state == S_IDLE) && lsu_win;
    mem_req_valid = (state == S_ISSUE);
    busy          = (state != S_IDLE);
  end

  assign mem_addr  = req_q.addr;
  assign mem_wen   = req_q.wen;
  assign mem_wdata = req_q.wdata;
  assign mem_wmask = req_q.wmask;

  // Request latch, streak counter, response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q          <= '0;
      owner_lsu      <= 1'b0;
      streak         <= '0;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_rdata      <= '0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      if (state == S_IDLE && grant) begin
        owner_lsu   <= lsu_win;
        req_q.addr  <= lsu_win ? lsu_addr : ifu_addr;
        req_q.wen   <= lsu_win && lsu_wen;
        req_q.wdata <= lsu_win ? lsu_wdata : '0;
        req_q.wmask <= lsu_win ? lsu_wmask : '0;
        // Streak only grows while the IFU is actually being passed over.
        if (lsu_win && ifu_req_valid)
          streak <= (streak == STK_W'(MAX_LSU_STREAK)) ? streak : streak + STK_W'(1);
        else
          streak <= '0;
      end
      if (done) begin
        // A timeout with no real response returns zero data.
        if (owner_lsu) begin
          lsu_resp_valid <= 1'b1;
          lsu_rdata      <= mem_resp_valid ? mem_rdata : '0;
        end else begin
          ifu_resp_valid <= 1'b1;
          ifu_rdata      <= mem_resp_valid ? mem_rdata : '0;
        end
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT+1) > 8) ? $clog2(TIMEOUT+1) : 8;
  logic [TO_W-1:0] tcnt;

  // Counts WAIT cycles; the TIMEOUT-th silent cycle completes the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          tcnt <= '0;
    else if (state == S_WAIT && !done)   tcnt <= tcnt + TO_W'(1);
    else                                 tcnt <= '0;
  end

  assign tmo = (state == S_WAIT) && (tcnt == TO_W'(TIMEOUT-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_err <= 1'b0;
    else        resp_err <= done && !mem_resp_valid;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo      = 1'b0;
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        resp_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LSU_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic        is_lsu;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] mrdata;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_mask;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive point: just after the rising edge. Sample point: falling edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifu_req_valid  = 1'b0;
    lsu_req_valid  = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_ifu_ready"}, ifu_req_ready, 0);
    chk({p, "_lsu_ready"}, lsu_req_ready, 0);
    chk({p, "_ifu_rv"},    ifu_resp_valid, 0);
    chk({p, "_lsu_rv"},    lsu_resp_valid, 0);
    chk({p, "_ifu_rdata"}, ifu_rdata, 0);
    chk({p, "_lsu_rdata"}, lsu_rdata, 0);
    chk({p, "_mreq_v"},    mem_req_valid, 0);
    chk({p, "_maddr"},     mem_addr, 0);
    chk({p, "_mwen"},      mem_wen, 0);
    chk({p, "_mwdata"},    mem_wdata, 0);
    chk({p, "_mwmask"},    mem_wmask, 0);
    chk({p, "_err"},       resp_err, 0);
    chk({p, "_busy"},      busy, 0);
  endtask

  vec_t vt [6];
  bit   exp_l [10];

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h80000000, 32'h0, 4'h0, 32'h00000413, 1'b0, 32'h0, 4'h0, 32'h00000413};
    vt[1] = '{1'b1, 1'b0, 32'h80000010, 32'h0, 4'h0, 32'h12345678, 1'b0, 32'h0, 4'h0, 32'h12345678};
    vt[2] = '{1'b1, 1'b1, 32'h80001000, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b1, 32'hDEADBEEF, 4'hF, 32'h00000000};
    vt[3] = '{1'b1, 1'b1, 32'h80001004, 32'hCAFEF00D, 4'h3, 32'hA5A5A5A5, 1'b1, 32'hCAFEF00D, 4'h3, 32'hA5A5A5A5};
    vt[4] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0, 4'h0, 32'hFFFFFFFF};
    vt[5] = '{1'b1, 1'b0, 32'h00000000, 32'h0, 4'h0, 32'h80000001, 1'b0, 32'h0, 4'h0, 32'h80000001};
    exp_l = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    rst_n = 1'b0;
    idle_inputs();
    ifu_addr = '0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    smp();
    chk_zero("reset");
    step();
    rst_n = 1'b1;

    // ---- table: single-requester transactions, best-case latency ----
    for (int i = 0; i < 6; i++) begin
      if (vt[i].is_lsu) begin
        lsu_req_valid = 1'b1; lsu_addr = vt[i].addr; lsu_wen = vt[i].wen;
        lsu_wdata = vt[i].wdata; lsu_wmask = vt[i].mask; ifu_addr = 32'h0BAD0BAD;
      end else begin
        ifu_req_valid = 1'b1; ifu_addr = vt[i].addr;
        lsu_wen = 1'b1; lsu_wdata = 32'hFFFFFFFF; lsu_wmask = 4'hF;
      end
      smp();
      chk($sformatf("t%0d_ifu_ready", i), ifu_req_ready, !vt[i].is_lsu);
      chk($sformatf("t%0d_lsu_ready", i), lsu_req_ready, vt[i].is_lsu);
      step();
      idle_inputs(); mem_req_ready = 1'b1;
      smp();
      chk($sformatf("t%0d_mreq_v", i), mem_req_valid, 1);
      chk($sformatf("t%0d_maddr", i),  mem_addr, vt[i].addr);
      chk($sformatf("t%0d_mwen", i),   mem_wen, vt[i].exp_wen);
      chk($sformatf("t%0d_mwdata", i), mem_wdata, vt[i].exp_wdata);
      chk($sformatf("t%0d_mwmask", i), mem_wmask, vt[i].exp_mask);
      step();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = vt[i].mrdata;
      smp();
      chk($sformatf("t%0d_early_rv", i), ifu_resp_valid | lsu_resp_valid, 0);
      step();
      mem_resp_valid = 1'b0; mem_rdata = 32'h0;
      smp();
      chk($sformatf("t%0d_ifu_rv", i), ifu_resp_valid, !vt[i].is_lsu);
      chk($sformatf("t%0d_lsu_rv", i), lsu_resp_valid, vt[i].is_lsu);
      chk($sformatf("t%0d_rdata", i), vt[i].is_lsu ? lsu_rdata : ifu_rdata, vt[i].exp_rdata);
      chk($sformatf("t%0d_err", i), resp_err, 0);
      chk($sformatf("t%0d_busy", i), busy, 0);
      step();
      smp();
      chk($sformatf("t%0d_pulse", i), ifu_resp_valid | lsu_resp_valid, 0);
      step();
    end

    // ---- both request: LSU first, IFU accepted on LSU response cycle ----
    lsu_req_valid = 1'b1; lsu_addr = 32'h80001000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEADBEEF; lsu_wmask = 4'hF;
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000008;
    smp();
    chk("both_lsu_ready", lsu_req_ready, 1);
    chk("both_ifu_ready", ifu_req_ready, 0);
    step();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk("both_issue_ifu_ready", ifu_req_ready, 0);
    chk("both_mwen", mem_wen, 1);
    chk("both_mwmask", mem_wmask, 4'hF);
    chk("both_mwdata", mem_wdata, 32'hDEADBEEF);
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h55AA55AA;
    smp();
    chk("both_wait_ifu_ready", ifu_req_ready, 0);
    step();
    mem_resp_valid = 1'b0;
    smp();
    chk("both_lsu_rv", lsu_resp_valid, 1);
    chk("both_ifu_accept", ifu_req_ready, 1);
    chk("both_lsu_rdata", lsu_rdata, 32'h55AA55AA);
    step();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk("both_ifu_maddr", mem_addr, 32'h80000008);
    chk("both_ifu_mwen", mem_wen, 0);
    chk("both_ifu_mwmask", mem_wmask, 0);
    chk("both_ifu_mwdata", mem_wdata, 0);
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h00000013;
    step();
    mem_resp_valid = 1'b0;
    smp();
    chk("both_ifu_rv", ifu_resp_valid, 1);
    chk("both_ifu_rdata", ifu_rdata, 32'h00000013);
    chk("both_lsu_rdata_hold", lsu_rdata, 32'h55AA55AA);
    step();

    // ---- starvation guard: both always valid ----
    begin
      int ng = 0;
      lsu_req_valid = 1'b1; lsu_addr = 32'h80004000; lsu_wen = 1'b0; lsu_wmask = 4'h0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h80000020;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h11111111;
      for (int c = 0; c < 60 && ng < 10; c++) begin
        smp();
        if (ifu_req_ready || lsu_req_ready) begin
          chk($sformatf("streak_grant%0d_is_lsu", ng), lsu_req_ready, exp_l[ng]);
          chk($sformatf("streak_grant%0d_onehot", ng), ifu_req_ready & lsu_req_ready, 0);
          ng++;
        end
        step();
      end
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      chk("streak_grant_count", ng, 10);
      repeat (3) step();
      idle_inputs();
      step();
    end

    // ---- memory stalls in ISSUE ----
    lsu_req_valid = 1'b1; lsu_addr = 32'h80002000; lsu_wen = 1'b1;
    lsu_wdata = 32'h0BADF00D; lsu_wmask = 4'h5;
    smp();
    chk("stall_accept", lsu_req_ready, 1);
    step();
    lsu_addr = 32'h12121212; lsu_wdata = 32'h34343434; lsu_wmask = 4'hA; lsu_wen = 1'b0;
    ifu_req_valid = 1'b1; mem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk($sformatf("stall%0d_mreq_v", k), mem_req_valid, 1);
      chk($sformatf("stall%0d_maddr", k), mem_addr, 32'h80002000);
      chk($sformatf("stall%0d_mwdata", k), mem_wdata, 32'h0BADF00D);
      chk($sformatf("stall%0d_mwmask", k), mem_wmask, 4'h5);
      chk($sformatf("stall%0d_mwen", k), mem_wen, 1);
      chk($sformatf("stall%0d_readies", k), {ifu_req_ready, lsu_req_ready}, 0);
      chk($sformatf("stall%0d_busy", k), busy, 1);
      step();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk("stall_end_mreq_v", mem_req_valid, 1);
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h77777777;
    step();
    mem_resp_valid = 1'b0;
    smp();
    chk("stall_lsu_rv", lsu_resp_valid, 1);
    chk("stall_lsu_rdata", lsu_rdata, 32'h77777777);
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    // ---- timeout with TIMEOUT=8 ----
    lsu_req_valid = 1'b1; lsu_addr = 32'h80003000; lsu_wen = 1'b0; lsu_wmask = 4'h0;
    step();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int k = 2; k < 10; k++) begin
      smp();
      chk($sformatf("to_c%0d_rv", k), lsu_resp_valid, 0);
      chk($sformatf("to_c%0d_busy", k), busy, 1);
      step();
    end
    smp();
    chk("to_lsu_rv", lsu_resp_valid, 1);
    chk("to_err", resp_err, 1);
    chk("to_rdata", lsu_rdata, 0);
    chk("to_busy", busy, 0);
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'hDEADDEAD;
    smp();
    chk("to_err_pulse", resp_err, 0);
    step();
    mem_resp_valid = 1'b0;
    smp();
    chk("to_late_rv", lsu_resp_valid | ifu_resp_valid, 0);
    chk("to_late_rdata", lsu_rdata, 0);
    step();
`else
    // ---- no timeout: WAIT holds until memory answers ----
    lsu_req_valid = 1'b1; lsu_addr = 32'h80003000; lsu_wen = 1'b0; lsu_wmask = 4'h0;
    step();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      smp();
      chk($sformatf("nto_c%0d_rv", k), lsu_resp_valid, 0);
      chk($sformatf("nto_c%0d_busy", k), busy, 1);
      step();
    end
    mem_resp_valid = 1'b1; mem_rdata = 32'h3C3C3C3C;
    step();
    mem_resp_valid = 1'b0;
    smp();
    chk("nto_lsu_rv", lsu_resp_valid, 1);
    chk("nto_err", resp_err, 0);
    chk("nto_rdata", lsu_rdata, 32'h3C3C3C3C);
    step();
`endif

    // ---- reset pulsed while in WAIT ----
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000100;
    step();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    smp();
    chk("rstw_busy", busy, 1);
    chk("rstw_mreq_v", mem_req_valid, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rstw");
    step();
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 32'h00000BAD;
    step();
    mem_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("rstw_after%0d_rv", k), ifu_resp_valid | lsu_resp_valid, 0);
      chk($sformatf("rstw_after%0d_busy", k), busy, 0);
      chk($sformatf("rstw_after%0d_ifu_rdata", k), ifu_rdata, 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
